// File: rtl/rename_stage.sv
// rename_stage: maps architectural sources/destination of each decoded
// instruction to physical registers through a register alias table (RAT),
// allocates new destinations from a circular free list, and registers the
// renamed instruction plus decode controls for dispatch (1-cycle latency).
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   decoded instruction handshake (in_ready combinational)
//   in_*                  decode fields; in_reg_write also gates allocation
//   free_valid/free_preg  commit-side release of a physical tag
//   out_valid, out_prs1/2 renamed instruction and physical sources
//   out_prd/out_old_prd   new destination and previous mapping (0 if none)
//   out_* passthrough     registered copies of the decode fields
//   overflow_err          sticky: a free arrived while the list was full
module rename_stage #(
    parameter int unsigned NUM_PREG = 64,
    parameter int unsigned PREG_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic [2:0]        in_func3,
    input  logic              in_load_store,
    input  logic              in_alu_src,
    input  logic              in_reg_write,
    input  logic              in_bms,
    input  logic [3:0]        in_alu_control,
    input  logic              free_valid,
    input  logic [PREG_W-1:0] free_preg,
    output logic              out_valid,
    output logic [PREG_W-1:0] out_prs1,
    output logic [PREG_W-1:0] out_prs2,
    output logic [PREG_W-1:0] out_prd,
    output logic [PREG_W-1:0] out_old_prd,
    output logic [6:0]        out_opcode,
    output logic [31:0]       out_imm,
    output logic [2:0]        out_func3,
    output logic              out_load_store,
    output logic              out_alu_src,
    output logic              out_reg_write,
    output logic              out_bms,
    output logic [3:0]        out_alu_control,
    output logic              overflow_err
);

    localparam int unsigned NUM_AREG = 32;
    localparam int unsigned FL_DEPTH = NUM_PREG - NUM_AREG;
    localparam int unsigned FL_PTR_W = $clog2(FL_DEPTH);
    localparam int unsigned FL_CNT_W = $clog2(FL_DEPTH + 1);

    // Architectural and free-list state
    logic [PREG_W-1:0]   rat_q [NUM_AREG];
    logic [PREG_W-1:0]   rat_d [NUM_AREG];
    logic [PREG_W-1:0]   fl_q  [FL_DEPTH];
    logic [PREG_W-1:0]   fl_d  [FL_DEPTH];
    logic [FL_PTR_W-1:0] head_q, head_d;
    logic [FL_PTR_W-1:0] tail_q, tail_d;
    logic [FL_CNT_W-1:0] free_count_q, free_count_d;
    logic                overflow_err_q, overflow_err_d;

    // Output register
    logic              out_valid_q, out_valid_d;
    logic [PREG_W-1:0] out_prs1_q, out_prs1_d;
    logic [PREG_W-1:0] out_prs2_q, out_prs2_d;
    logic [PREG_W-1:0] out_prd_q, out_prd_d;
    logic [PREG_W-1:0] out_old_prd_q, out_old_prd_d;
    logic [6:0]        out_opcode_q, out_opcode_d;
    logic [31:0]       out_imm_q, out_imm_d;
    logic [2:0]        out_func3_q, out_func3_d;
    logic              out_load_store_q, out_load_store_d;
    logic              out_alu_src_q, out_alu_src_d;
    logic              out_reg_write_q, out_reg_write_d;
    logic              out_bms_q, out_bms_d;
    logic [3:0]        out_alu_control_q, out_alu_control_d;

    logic need_alloc;
    logic fl_empty;
    logic fl_full;
    logic accept;
    logic do_alloc;
    logic free_req;
    logic do_free;

    function automatic logic [FL_PTR_W-1:0] ptr_inc(input logic [FL_PTR_W-1:0] p);
        return (p == FL_PTR_W'(FL_DEPTH - 1)) ? '0 : p + FL_PTR_W'(1);
    endfunction

    // Handshake and update enables; a same-cycle free never feeds an empty list's allocation
    always_comb begin
        need_alloc = in_reg_write & (in_rd != 5'd0);
        fl_empty   = (free_count_q == '0);
        fl_full    = (free_count_q == FL_CNT_W'(FL_DEPTH));
        in_ready   = ~fl_empty | ~need_alloc;
        accept     = in_valid & in_ready;
        do_alloc   = accept & need_alloc;
        free_req   = free_valid & (free_preg != '0);
        do_free    = free_req & ~fl_full;
    end

    // Next-state: RAT, free list, counters and output register
    always_comb begin
        rat_d             = rat_q;
        fl_d              = fl_q;
        head_d            = head_q;
        tail_d            = tail_q;
        free_count_d      = free_count_q;
        overflow_err_d    = overflow_err_q | (free_req & fl_full);
        out_valid_d       = accept;
        out_prs1_d        = out_prs1_q;
        out_prs2_d        = out_prs2_q;
        out_prd_d         = out_prd_q;
        out_old_prd_d     = out_old_prd_q;
        out_opcode_d      = out_opcode_q;
        out_imm_d         = out_imm_q;
        out_func3_d       = out_func3_q;
        out_load_store_d  = out_load_store_q;
        out_alu_src_d     = out_alu_src_q;
        out_reg_write_d   = out_reg_write_q;
        out_bms_d         = out_bms_q;
        out_alu_control_d = out_alu_control_q;

        if (accept) begin
            // Sources read the pre-write RAT, so rs == rd sees the old mapping
            out_prs1_d        = rat_q[in_rs1];
            out_prs2_d        = rat_q[in_rs2];
            out_prd_d         = do_alloc ? fl_q[head_q] : '0;
            out_old_prd_d     = do_alloc ? rat_q[in_rd] : '0;
            out_opcode_d      = in_opcode;
            out_imm_d         = in_imm;
            out_func3_d       = in_func3;
            out_load_store_d  = in_load_store;
            out_alu_src_d     = in_alu_src;
            out_reg_write_d   = in_reg_write;
            out_bms_d         = in_bms;
            out_alu_control_d = in_alu_control;
        end

        if (do_alloc) begin
            rat_d[in_rd] = fl_q[head_q];
            head_d       = ptr_inc(head_q);
        end

        if (do_free) begin
            fl_d[tail_q] = free_preg;
            tail_d       = ptr_inc(tail_q);
        end

        case ({do_alloc, do_free})
            2'b10:   free_count_d = free_count_q - FL_CNT_W'(1);
            2'b01:   free_count_d = free_count_q + FL_CNT_W'(1);
            default: free_count_d = free_count_q;
        endcase
    end

    // State registers; reset restores identity map and a full ascending free list
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_AREG; i++) begin
                rat_q[i] <= PREG_W'(i);
            end
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_q[i] <= PREG_W'(NUM_AREG + i);
            end
            head_q            <= '0;
            tail_q            <= '0;
            free_count_q      <= FL_CNT_W'(FL_DEPTH);
            overflow_err_q    <= 1'b0;
            out_valid_q       <= 1'b0;
            out_prs1_q        <= '0;
            out_prs2_q        <= '0;
            out_prd_q         <= '0;
            out_old_prd_q     <= '0;
            out_opcode_q      <= '0;
            out_imm_q         <= '0;
            out_func3_q       <= '0;
            out_load_store_q  <= 1'b0;
            out_alu_src_q     <= 1'b0;
            out_reg_write_q   <= 1'b0;
            out_bms_q         <= 1'b0;
            out_alu_control_q <= '0;
        end else begin
            rat_q             <= rat_d;
            fl_q              <= fl_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            free_count_q      <= free_count_d;
            overflow_err_q    <= overflow_err_d;
            out_valid_q       <= out_valid_d;
            out_prs1_q        <= out_prs1_d;
            out_prs2_q        <= out_prs2_d;
            out_prd_q         <= out_prd_d;
            out_old_prd_q     <= out_old_prd_d;
            out_opcode_q      <= out_opcode_d;
            out_imm_q         <= out_imm_d;
            out_func3_q       <= out_func3_d;
            out_load_store_q  <= out_load_store_d;
            out_alu_src_q     <= out_alu_src_d;
            out_reg_write_q   <= out_reg_write_d;
            out_bms_q         <= out_bms_d;
            out_alu_control_q <= out_alu_control_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_prs1        = out_prs1_q;
    assign out_prs2        = out_prs2_q;
    assign out_prd         = out_prd_q;
    assign out_old_prd     = out_old_prd_q;
    assign out_opcode      = out_opcode_q;
    assign out_imm         = out_imm_q;
    assign out_func3       = out_func3_q;
    assign out_load_store  = out_load_store_q;
    assign out_alu_src     = out_alu_src_q;
    assign out_reg_write   = out_reg_write_q;
    assign out_bms         = out_bms_q;
    assign out_alu_control = out_alu_control_q;
    assign overflow_err    = overflow_err_q;

endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: directed instructions push expected renamed
// packets into a scoreboard queue; a monitor pops and compares each
// out_valid packet on the falling edge.
module tb_rename_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic [2:0]  in_func3;
    logic        in_load_store, in_alu_src, in_reg_write, in_bms;
    logic [3:0]  in_alu_control;
    logic        free_valid;
    logic [5:0]  free_preg;
    logic        out_valid;
    logic [5:0]  out_prs1, out_prs2, out_prd, out_old_prd;
    logic [6:0]  out_opcode;
    logic [31:0] out_imm;
    logic [2:0]  out_func3;
    logic        out_load_store, out_alu_src, out_reg_write, out_bms;
    logic [3:0]  out_alu_control;
    logic        overflow_err;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        ls, as, rw, bms;
        logic [3:0]  ac;
    } ins_t;

    typedef struct {
        ins_t       ins;
        logic [5:0] p1, p2, pd, po;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Bench model used only for the long wrap-around run
    logic [5:0] mrat [32];
    logic [5:0] mfl[$];

    rename_stage #(.NUM_PREG(64), .PREG_W(6)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_func3(in_func3),
        .in_load_store(in_load_store), .in_alu_src(in_alu_src),
        .in_reg_write(in_reg_write), .in_bms(in_bms),
        .in_alu_control(in_alu_control),
        .free_valid(free_valid), .free_preg(free_preg),
        .out_valid(out_valid), .out_prs1(out_prs1), .out_prs2(out_prs2),
        .out_prd(out_prd), .out_old_prd(out_old_prd),
        .out_opcode(out_opcode), .out_imm(out_imm), .out_func3(out_func3),
        .out_load_store(out_load_store), .out_alu_src(out_alu_src),
        .out_reg_write(out_reg_write), .out_bms(out_bms),
        .out_alu_control(out_alu_control),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic rw, input logic [31:0] imm);
        ins_t t;
        t.op  = op;  t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
        t.imm = imm; t.rw = rw;
        t.f3  = rd[2:0];
        t.ls  = ~rw;
        t.as  = imm[0];
        t.bms = rs2[0];
        t.ac  = rs1[3:0];
        return t;
    endfunction

    task automatic drive(input ins_t t);
        in_valid       = 1'b1;
        in_opcode      = t.op;  in_rd = t.rd; in_rs1 = t.rs1; in_rs2 = t.rs2;
        in_imm         = t.imm; in_func3 = t.f3;
        in_load_store  = t.ls;  in_alu_src = t.as;
        in_reg_write   = t.rw;  in_bms = t.bms;
        in_alu_control = t.ac;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input ins_t t, input logic [5:0] p1, input logic [5:0] p2,
                        input logic [5:0] pd, input logic [5:0] po,
                        input logic fv, input logic [5:0] fp);
        exp_t e;
        int   waited = 0;
        drive(t);
        free_valid = fv;
        free_preg  = fp;
        #1;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            e.ins = t; e.p1 = p1; e.p2 = p2; e.pd = pd; e.po = po;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        free_valid = 1'b0;
        free_preg  = '0;
    endtask

    task automatic do_reset(input bit drain);
        if (drain) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        sb.delete();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_prd", 64'(out_prd), 64'd0);
        chk("rst_overflow", 64'(overflow_err), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Monitor: every valid output must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_prs1", 64'(out_prs1), 64'(e.p1));
                chk("out_prs2", 64'(out_prs2), 64'(e.p2));
                chk("out_prd", 64'(out_prd), 64'(e.pd));
                chk("out_old_prd", 64'(out_old_prd), 64'(e.po));
                chk("out_passthru",
                    64'({out_opcode, out_imm, out_func3, out_load_store, out_alu_src,
                         out_reg_write, out_bms, out_alu_control}),
                    64'({e.ins.op, e.ins.imm, e.ins.f3, e.ins.ls, e.ins.as,
                         e.ins.rw, e.ins.bms, e.ins.ac}));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rd;
        logic [5:0] pd, po;
        reset = 1'b1;
        in_valid = 1'b0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; in_func3 = '0; in_load_store = 1'b0; in_alu_src = 1'b0;
        in_reg_write = 1'b0; in_bms = 1'b0; in_alu_control = '0;
        free_valid = 1'b0; free_preg = '0;

        // Reset state
        @(posedge clk); #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_overflow", 64'(overflow_err), 64'd0);
        chk("reset_out_prs1", 64'(out_prs1), 64'd0);
        reset = 1'b0;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // ADD x5,x1,x2 then dependent ADD x6,x5,x5
        send(mk(7'h33, 5'd5, 5'd1, 5'd2, 1'b1, 32'h0), 6'd1, 6'd2, 6'd32, 6'd5, 1'b0, 6'd0);
        send(mk(7'h33, 5'd6, 5'd5, 5'd5, 1'b1, 32'h0), 6'd32, 6'd32, 6'd33, 6'd6, 1'b0, 6'd0);

        // ADDI x7,x7,1 twice back-to-back
        do_reset(1'b1);
        send(mk(7'h13, 5'd7, 5'd7, 5'd0, 1'b1, 32'd1), 6'd7, 6'd0, 6'd32, 6'd7, 1'b0, 6'd0);
        send(mk(7'h13, 5'd7, 5'd7, 5'd0, 1'b1, 32'd1), 6'd32, 6'd0, 6'd33, 6'd32, 1'b0, 6'd0);

        // Drain the free list with 32 allocations
        do_reset(1'b1);
        for (int i = 0; i < 32; i++) begin
            rd = 5'((i % 31) + 1);
            po = (i < 31) ? 6'(i + 1) : 6'd32;
            send(mk(7'h33, rd, 5'd0, 5'd0, 1'b1, 32'(i)), 6'd0, 6'd0, 6'(32 + i), po, 1'b0, 6'd0);
        end
        // Non-allocating instructions still flow with an empty list
        send(mk(7'h23, 5'd3, 5'd3, 5'd4, 1'b0, 32'h10), 6'd34, 6'd35, 6'd0, 6'd0, 1'b0, 6'd0);
        send(mk(7'h13, 5'd0, 5'd5, 5'd0, 1'b1, 32'h20), 6'd36, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0);
        // 33rd allocation stalls until a free, with no bypass in the free cycle
        drive(mk(7'h33, 5'd2, 5'd1, 5'd2, 1'b1, 32'h33));
        #1;
        chk("empty_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd0);
        end
        free_valid = 1'b1;
        free_preg  = 6'd40;
        #1;
        chk("free_cycle_no_bypass", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        free_valid = 1'b0;
        free_preg  = '0;
        chk("after_free_in_ready", 64'(in_ready), 64'd1);
        send(mk(7'h33, 5'd2, 5'd1, 5'd2, 1'b1, 32'h33), 6'd63, 6'd33, 6'd40, 6'd33, 1'b0, 6'd0);

        // Simultaneous allocate/free at free_count 10 keeps the count at 10
        do_reset(1'b1);
        for (int i = 0; i < 22; i++) begin
            send(mk(7'h33, 5'(i + 1), 5'd0, 5'd0, 1'b1, 32'(i)), 6'd0, 6'd0, 6'(32 + i), 6'(i + 1), 1'b0, 6'd0);
        end
        send(mk(7'h33, 5'd23, 5'd0, 5'd0, 1'b1, 32'h5), 6'd0, 6'd0, 6'd54, 6'd23, 1'b1, 6'd50);
        for (int j = 0; j < 10; j++) begin
            rd = (j < 8) ? 5'(24 + j) : 5'(j - 7);
            pd = (j < 9) ? 6'(55 + j) : 6'd50;
            po = (j < 8) ? 6'(24 + j) : ((j == 8) ? 6'd32 : 6'd33);
            send(mk(7'h33, rd, 5'd0, 5'd0, 1'b1, 32'(j)), 6'd0, 6'd0, pd, po, 1'b0, 6'd0);
        end
        drive(mk(7'h33, 5'd3, 5'd0, 5'd0, 1'b1, 32'h0));
        #1;
        chk("count10_exhausted", 64'(in_ready), 64'd0);
        in_valid = 1'b0;

        // 100 allocate/free pairs wrap head and tail; FIFO order tracked by model
        do_reset(1'b1);
        for (int i = 0; i < 32; i++) mrat[i] = 6'(i);
        mfl.delete();
        for (int i = 32; i < 64; i++) mfl.push_back(6'(i));
        for (int k = 0; k <= 100; k++) begin
            logic [4:0] r1, r2;
            logic [5:0] p1, p2;
            rd = 5'((k % 31) + 1);
            r1 = 5'((k * 7 + 3) % 32);
            r2 = 5'((k * 5 + 1) % 32);
            p1 = mrat[r1];
            p2 = mrat[r2];
            pd = mfl.pop_front();
            po = mrat[rd];
            mrat[rd] = pd;
            if (k > 0) mfl.push_back(po);
            send(mk(7'h33, rd, r1, r2, 1'b1, 32'(k)), p1, p2, pd, po, (k > 0), po);
        end

        // Overflow: free of 0 ignored, free into full list is sticky
        do_reset(1'b1);
        free_valid = 1'b1; free_preg = 6'd0;
        @(posedge clk); #1;
        free_valid = 1'b0;
        chk("free0_no_overflow", 64'(overflow_err), 64'd0);
        free_valid = 1'b1; free_preg = 6'd45;
        @(posedge clk); #1;
        free_valid = 1'b0; free_preg = 6'd0;
        chk("overflow_set", 64'(overflow_err), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("overflow_sticky", 64'(overflow_err), 64'd1);
        send(mk(7'h33, 5'd1, 5'd2, 5'd3, 1'b1, 32'h7), 6'd2, 6'd3, 6'd32, 6'd1, 1'b0, 6'd0);
        chk("overflow_sticky2", 64'(overflow_err), 64'd1);

        // Reset with an output in flight, then identity RAT and tag 32 again
        send(mk(7'h33, 5'd1, 5'd1, 5'd1, 1'b1, 32'h8), 6'd32, 6'd32, 6'd33, 6'd32, 1'b0, 6'd0);
        do_reset(1'b0);
        send(mk(7'h33, 5'd5, 5'd1, 5'd2, 1'b1, 32'h9), 6'd1, 6'd2, 6'd32, 6'd5, 1'b0, 6'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rename_stage.md
# rename_stage

Register-rename stage sitting directly downstream of the decode stage. Each valid decoded instruction has its architectural sources mapped to physical registers through a register alias table (RAT). A new physical destination is allocated from a circular free list, and the old mapping is reported for later release. Decode control fields are carried alongside in a one-deep output register for the dispatch/issue stage.

## Interface
Parameters:
- NUM_PREG, 64, number of physical registers; must be a power of two, > 32.
- PREG_W, 6, physical tag width, equal to log2(NUM_PREG).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept this cycle (combinational).
- in_opcode  in  7  passthrough.
- in_rd, in_rs1, in_rs2  in  5 each  architectural registers.
- in_imm  in  32  passthrough.
- in_func3  in  3  passthrough.
- in_load_store, in_alu_src, in_reg_write, in_bms  in  1 each  control; in_reg_write also gates allocation.
- in_alu_control  in  4  passthrough.
- free_valid  in  1  commit releases a physical register.
- free_preg  in  PREG_W  tag being released.
- out_valid  out  1  renamed instruction valid.
- out_prs1, out_prs2  out  PREG_W each  physical sources.
- out_prd  out  PREG_W  allocated destination; 0 if none allocated.
- out_old_prd  out  PREG_W  previous mapping of rd; 0 if none allocated.
- out_opcode, out_imm, out_func3, out_load_store, out_alu_src, out_reg_write, out_bms, out_alu_control  out  registered copies of the inputs.
- overflow_err  out  1  sticky; set by a free into a full free list.

## Operation
- need_alloc = in_reg_write & (in_rd != 0).
- in_ready = (free_count != 0) | ~need_alloc.
- accept = in_valid & in_ready.
- Sources: out_prs1 = RAT[in_rs1] and out_prs2 = RAT[in_rs2], read before this cycle's RAT write. If rs1 or rs2 equals rd, the source gets the old mapping.
- x0: RAT[0] is always 0 and is never written.
- On accept with need_alloc:
  - out_prd = tag at the free-list head.
  - out_old_prd = RAT[in_rd].
  - RAT[in_rd] <= head tag.
  - head advances and free_count decrements.
- On accept without need_alloc: out_prd = 0, out_old_prd = 0, and the RAT and free list are unchanged.
- Free list: circular buffer of NUM_PREG-32 entries with head/tail pointers that wrap modulo the depth, plus free_count in the range 0..NUM_PREG-32.
- On free_valid with free_preg != 0 and the list not full: write the tag at the tail, advance tail, increment free_count.
  - free_preg == 0: ignored.
  - List full: the free is dropped and overflow_err is set.
- Allocate and free in the same cycle: both take effect and free_count is unchanged.
- An empty list plus a same-cycle free does not bypass. in_ready stays low that cycle and the instruction is accepted the next cycle.
- Stall: when in_ready = 0, upstream holds its inputs; the RAT and free list are unchanged and out_valid <= 0.
- The stage never drops an accepted instruction. There is no output backpressure; downstream always consumes out_valid.

## Timing
- Latency: 1 cycle. An instruction accepted in cycle N appears with out_valid = 1 in cycle N+1.
- Throughput: 1 instruction per cycle while free_count > 0.
- Reset (asynchronous) sets:
  - RAT[i] = i for i = 0..31.
  - Free list holding tags 32..NUM_PREG-1 in ascending order; head = 0, tail = 0, free_count = NUM_PREG-32 (full).
  - out_valid = 0, overflow_err = 0, and all other outputs 0.
- Reset mid-stream discards any in-flight output and all mappings. The first accept after deassertion allocates tag 32.
- RAT writes and free-list updates are visible to the instruction accepted in the next cycle (back-to-back dependency).

## Test plan
- Reset, then ADD x5,x1,x2 (reg_write=1) -> next cycle out_valid=1, prs1=1, prs2=2, prd=32, old_prd=5. A following ADD x6,x5,x5 -> prs1=prs2=32, prd=33, old_prd=6.
- ADDI x7,x7,1 twice back-to-back -> first gives prs1=7, prd=32, old_prd=7; second gives prs1=32, prd=33, old_prd=32.
- 32 allocating instructions with no frees -> prd 32..63 in order and free_count=0. The 33rd sees in_ready=0 and out_valid=0 until free_preg=40 arrives. It is accepted the cycle after the free and gets prd=40.
- Store (reg_write=0) and a write to x0 while free_count=0 -> in_ready=1, prd=0, old_prd=0, RAT unchanged.
- Simultaneous allocate and free_preg=50 at free_count=10 -> free_count stays 10. Tail wrap-around is verified by cycling 100 allocate/free pairs and checking the FIFO order of returned tags.
- free_valid with free_preg=45 at full list -> overflow_err=1 and stays set until reset; free_preg=0 -> no effect. Asserting reset mid-stream -> outputs 0 immediately and the RAT returns to identity.
